xoodyak_host_feeder: RTL

- Host-side initiator for the Xoodyak hash core.
- Buffers an upstream byte stream in a FIFO and issues the start pulse and message length.
- Streams message bytes to the core under its busy handshake, zero-filling the last partial 16-byte block.
- Collects the 32 squeezed hash bytes into a 256-bit digest with a one-cycle done pulse.

---
 rtl/xoodyak_host_feeder_if.sv | 32 +++
 rtl/xoodyak_host_feeder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/xoodyak_host_feeder_if.sv
// Handshake and bus bundle between the host environment and the Xoodyak host feeder.
// master: upstream byte source, go/length control and the core's response side.
// slave:  the feeder itself.
interface xoodyak_host_feeder_if #(
   parameter int unsigned DIGEST_BYTES = 32
);
   logic [7:0]                  in_data;
   logic                        in_valid;
   logic                        in_ready;
   logic [11:0]                 msg_len;
   logic                        go;
   logic                        core_start;
   logic [7:0]                  core_msg;
   logic [11:0]                 core_msg_len;
   logic                        core_busy;
   logic [7:0]                  core_hash;
   logic                        core_valid;
   logic [8*DIGEST_BYTES-1:0]   digest;
   logic                        digest_valid;
   logic                        busy;
   logic                        error;

   modport master (
      output in_data, in_valid, msg_len, go, core_busy, core_hash, core_valid,
      input  in_ready, core_start, core_msg, core_msg_len, digest, digest_valid, busy, error
   );

   modport slave (
      input  in_data, in_valid, msg_len, go, core_busy, core_hash, core_valid,
      output in_ready, core_start, core_msg, core_msg_len, digest, digest_valid, busy, error
   );
endinterface

// File: rtl/xoodyak_host_feeder.sv
// Host-side initiator for the Xoodyak hash core: buffers upstream bytes in a FIFO, starts the
// core, streams the message zero-padded to whole 16-byte blocks, then gathers the digest.
// Optional watchdog: define XOODYAK_HOST_TIMEOUT_EN to abort stalled operations with error set.
module xoodyak_host_feeder #(
   parameter int unsigned FIFO_DEPTH   = 32,
   parameter int unsigned DIGEST_BYTES = 32,
   parameter int unsigned TIMEOUT_W    = 12
) (
   input logic                  clk,
   input logic                  resetn,
   xoodyak_host_feeder_if.slave bus
);
   localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW    = PtrW + 1;
   localparam int unsigned HashW   = $clog2(DIGEST_BYTES + 1);
   localparam int unsigned DigestW = 8 * DIGEST_BYTES;

   typedef enum logic [2:0] {StIdle, StStart, StFeed, StWaitHash, StCollect, StDone} state_e;

   state_e              state_q, state_d;
   logic [7:0]          mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]     count_q;
   logic                push, pop, fifo_empty;
   logic [11:0]         len_q, len_d;
   logic [12:0]         feed_cnt_q, feed_cnt_d, feed_total, next_idx, load_idx;
   logic                load_en;
   logic [HashW-1:0]    hash_cnt_q, hash_cnt_d;
   logic [DigestW-1:0]  digest_q, digest_d;
   logic [7:0]          msg_q, msg_d;
   logic                err_q, err_d;
   logic                consume, capture;

`ifdef XOODYAK_HOST_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
`else
   logic                 unused_timeout_w;
   assign unused_timeout_w = ^TIMEOUT_W;
`endif

   assign bus.in_ready = (count_q != CntW'(FIFO_DEPTH));
   assign push         = bus.in_valid && bus.in_ready;
   assign fifo_empty   = (count_q == '0);

   // Message is padded to whole 16-byte blocks; an empty message still sends one block.
   assign feed_total = (len_q == 12'd0) ? 13'd16 : (({1'b0, len_q} + 13'd15) & ~13'd15);
   assign next_idx   = feed_cnt_q + 13'd1;

   // FIFO storage; validity is tracked by the pointers, so no reset needed.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_data;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + CntW'(push) - CntW'(pop);
      end
   end

   // Control state and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         len_q      <= '0;
         feed_cnt_q <= '0;
         hash_cnt_q <= '0;
         digest_q   <= '0;
         msg_q      <= '0;
         err_q      <= 1'b0;
`ifdef XOODYAK_HOST_TIMEOUT_EN
         wdog_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         feed_cnt_q <= feed_cnt_d;
         hash_cnt_q <= hash_cnt_d;
         digest_q   <= digest_d;
         msg_q      <= msg_d;
         err_q      <= err_d;
`ifdef XOODYAK_HOST_TIMEOUT_EN
         wdog_q     <= wdog_d;
`endif
      end
   end

   // Next-state logic, byte fetch from the FIFO and digest capture.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      feed_cnt_d = feed_cnt_q;
      hash_cnt_d = hash_cnt_q;
      digest_d   = digest_q;
      msg_d      = msg_q;
      err_d      = err_q;
      pop        = 1'b0;
      load_en    = 1'b0;
      load_idx   = '0;
      consume    = 1'b0;
      capture    = 1'b0;
`ifdef XOODYAK_HOST_TIMEOUT_EN
      wdog_d     = '0;
`endif

      unique case (state_q)
         StIdle: begin
            if (bus.go) begin
               len_d      = bus.msg_len;
               err_d      = 1'b0;
               feed_cnt_d = '0;
               hash_cnt_d = '0;
               digest_d   = '0;
               state_d    = StStart;
            end
         end
         StStart: begin
            // Prefetch byte 0 so it is presented on the first FEED cycle.
            load_en  = 1'b1;
            load_idx = '0;
            state_d  = StFeed;
         end
         StFeed: begin
            if (!bus.core_busy) begin
               consume    = 1'b1;
               feed_cnt_d = next_idx;
               if (next_idx == feed_total) begin
                  msg_d   = 8'h00;
                  state_d = StWaitHash;
               end else begin
                  load_en  = 1'b1;
                  load_idx = next_idx;
               end
            end
         end
         StWaitHash, StCollect: begin
            if (bus.core_valid) begin
               capture                       = 1'b1;
               digest_d[8*hash_cnt_q +: 8]   = bus.core_hash;
               hash_cnt_d                    = hash_cnt_q + HashW'(1);
               state_d = (hash_cnt_d == HashW'(DIGEST_BYTES)) ? StDone : StCollect;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Message bytes come from the FIFO; padding is zero. An empty FIFO is an underflow.
      if (load_en) begin
         msg_d = 8'h00;
         if (load_idx < {1'b0, len_q}) begin
            if (fifo_empty) begin
               err_d = 1'b1;
            end else begin
               pop   = 1'b1;
               msg_d = mem_q[rd_ptr_q];
            end
         end
      end

`ifdef XOODYAK_HOST_TIMEOUT_EN
      // Abort only on a cycle with no progress, so nothing was popped or captured.
      if ((state_q inside {StFeed, StWaitHash, StCollect}) && !consume && !capture) begin
         if (wdog_q == '1) begin
            err_d   = 1'b1;
            msg_d   = 8'h00;
            state_d = StIdle;
         end else begin
            wdog_d = wdog_q + TIMEOUT_W'(1);
         end
      end
`endif
   end

   assign bus.core_start   = (state_q == StStart);
   assign bus.core_msg     = (state_q == StFeed) ? msg_q : 8'h00;
   assign bus.core_msg_len = len_q;
   assign bus.digest       = digest_q;
   assign bus.digest_valid = (state_q == StDone);
   assign bus.busy         = (state_q != StIdle);
   assign bus.error        = err_q;
endmodule
